// File: rtl/neg10_seq_pkg.sv
// Shared constants for the sequential two's-complement negation stage.
// State encoding, datapath width and the most-negative operand.
package neg10_seq_pkg;

  localparam int WIDTH = 10;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] INV  = 2'd1;
  localparam logic [1:0] INC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG = 10'b1000000000;

endpackage

// File: rtl/not10bit.sv
// Bitwise inversion of a 10-bit word.
// Purely combinational; feeds the negation stage.
module not10bit (
  input  logic [9:0] data_in,
  output logic [9:0] res
);

  assign res = ~data_in;

endmodule

// File: rtl/neg10_seq.sv
// Sequential 10-bit negation: invert, then bit-serial +1 over WIDTH cycles.
// res/overflow update together with a one-cycle done pulse.
module neg10_seq #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             overflow
);

  import neg10_seq_pkg::*;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] inv;
  logic [WIDTH-1:0] nxt_work;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  not10bit u_not (
    .data_in (operand),
    .res     (inv)
  );

  // One ripple-incrementer bit per cycle at position cnt.
  always_comb begin
    nxt_work      = work;
    nxt_work[cnt] = work[cnt] ^ carry;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      operand  <= '0;
      work     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      res      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (start) begin
            operand <= data_in;
            state   <= INV;
          end
        end
        (state == INV): begin
          work  <= inv;
          carry <= 1'b1;
          cnt   <= '0;
          state <= INC;
        end
        (state == INC): begin
          work  <= nxt_work;
          carry <= work[cnt] & carry;
          // Last bit: publish the finished word with the done pulse.
          if (cnt == LAST) begin
            res      <= nxt_work;
            overflow <= (operand == MIN_NEG);
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        (state == DONE): begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neg10_seq.sv
// Scoreboard bench for neg10_seq: random and directed operands,
// expected -A mod 1024 queued at issue, checked when done pulses.
module tb_neg10_seq;

  typedef struct {
    logic [9:0] res;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] data_in = '0;
  logic       busy;
  logic       done;
  logic [9:0] res;
  logic       overflow;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  neg10_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .res      (res),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [9:0] a, input int e0);
    exp_t e;
    e.res = 10'((1024 - int'(a)) % 1024);
    e.ovf = (int'(a) == 512);
    e.cyc = e0 + 11;
    return e;
  endfunction

  // Monitor: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        chk("done_not_repeated", int'(prev_done), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res", int'(res), int'(e.res));
          chk("overflow", int'(overflow), int'(e.ovf));
          chk("latency", cyc, e.cyc);
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [9:0] a);
    wait_idle();
    start   = 1'b1;
    data_in = a;
    sb.push_back(model(a, cyc + 1));
    @(negedge clk);
    start   = 1'b0;
    data_in = 10'($urandom);
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", int'(sb.size()), 0);
  endtask

  initial begin
    int c0;
    int bc;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_res", int'(res), 0);
    chk("reset_ovf", int'(overflow), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Busy must hold for exactly the 12 cycles between start and idle.
    issue(10'd1);
    bc = 1;
    while (busy && bc < 40) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("busy_cycles", bc, 12);

    issue(10'b0101010101);
    issue(10'b1111111111);
    issue(10'b0000000000);
    issue(10'b1000000000);
    drain();

    // Start while busy must be ignored.
    issue(10'd3);
    repeat (4) @(negedge clk);
    start   = 1'b1;
    data_in = 10'd7;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", int'(busy), 0);
    issue(10'd7);
    drain();

    // Asynchronous reset in the middle of INC aborts the operand.
    issue(10'd9);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_res", int'(res), 0);
    chk("abort_done", int'(done), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    issue(10'd2);
    drain();

    // Start held high: one result every 13 cycles.
    wait_idle();
    c0      = cyc;
    start   = 1'b1;
    data_in = 10'd5;
    for (int k = 0; k < 4; k++) sb.push_back(model(10'd5, c0 + 1 + 13 * k));
    repeat (51) @(negedge clk);
    start = 1'b0;
    drain();
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(10'($urandom_range(0, 1023)));
    end
    issue(10'd512);
    issue(10'd0);
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
